message_schedule_expander: RTL and testbench

MESSAGE_SCHEDULE_EXPANDER -- requirements
Module: message_schedule_expander

---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sched_sigma_adder.sv | 14 +
 rtl/message_schedule_expander.sv | 83 ++++++++
 tb/tb_message_schedule_expander.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word/block widths, round constants and message-schedule sigma functions.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sched_sigma_adder.sv
// sched_sigma_adder: combinational next schedule word from the sliding window taps.
module sched_sigma_adder
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] next_word
);

    assign next_word = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/message_schedule_expander.sv
// message_schedule_expander: streams the SHA-256 schedule W[t] of one 512-bit block, one word per cycle.
// Define SCHED_ADD_K_EN to emit W[t]+K[t] instead of W[t].
module message_schedule_expander
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] block_data,
    input  logic               block_valid,
    output logic               block_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [5:0]         w_index,
    output logic               w_last,
    output logic               w_valid,
    input  logic               w_ready
);

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] next_word;
    logic [5:0]        t;
    logic              accept, fire;

    assign block_ready = state == IDLE;
    assign w_valid     = state == RUN;
    assign w_index     = t;
    assign w_last      = w_valid && t == LAST_T;
    assign accept      = block_valid && block_ready;
    assign fire        = w_valid && w_ready;

    always_comb begin
        state_nx = state;
        if (state == IDLE && accept) state_nx = RUN;
        if (state == RUN && fire && w_last) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    sched_sigma_adder u_adder (
        .w0       (win[0]),
        .w1       (win[1]),
        .w9       (win[9]),
        .w14      (win[14]),
        .next_word(next_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            t <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) win[i] <= block_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            t <= '0;
        end else if (fire) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_word;
            t <= t + 6'd1;
        end
    end

`ifdef SCHED_ADD_K_EN
    // Precompute the next word's sum so the K addition costs no extra latency.
    logic [WORD_W-1:0] kw;
    logic [5:0]        t_nx;
    assign t_nx = t + 6'd1;
    always_ff @(posedge clk) begin
        if (reset)       kw <= '0;
        else if (accept) kw <= block_data[BLOCK_W-1 -: WORD_W] + K[0];
        else if (fire)   kw <= win[1] + K[t_nx];
    end
    assign w_data = kw;
`else
    assign w_data = win[0];
`endif

endmodule

// File: tb/tb_message_schedule_expander.sv
// tb_message_schedule_expander: directed checks of the schedule stream, stalls, reset and block overlap.
module tb_message_schedule_expander;

    logic         clk = 0;
    logic         reset = 1;
    logic [511:0] block_data = '0;
    logic         block_valid = 0;
    logic         block_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;
    logic         w_valid;
    logic         w_ready = 0;

    int           n_cmp = 0;
    int           n_err = 0;
    int           last_cycles;
    logic [31:0]  exp_w [64];
    logic [31:0]  got [64];
    logic [511:0] abc_blk, pad_blk;

    message_schedule_expander dut (
        .clk        (clk),
        .reset      (reset),
        .block_data (block_data),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .w_data     (w_data),
        .w_index    (w_index),
        .w_last     (w_last),
        .w_valid    (w_valid),
        .w_ready    (w_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] exp_out(input int n);
`ifdef SCHED_ADD_K_EN
        return exp_w[n] + sha256_pkg::K[n];
`else
        return exp_w[n];
`endif
    endfunction

    task automatic model(input logic [511:0] b);
        for (int i = 0; i < 64; i++)
            exp_w[i] = (i < 16) ? b[511-32*i -: 32]
                     : s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [511:0] b);
        n_cmp++;
        if (block_ready !== 1'b1) begin
            n_err++;
            $display("FAIL offer_ready: block_ready=%b required 1", block_ready);
        end
        block_data = b;
        block_valid = 1;
        tick();
        block_valid = 0;
    endtask

    task automatic consume(input int words, input int stall_pct);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] pd;
        logic [5:0] pi;
        logic pl;
        while (n < words && cyc < 1000) begin
            if (stalled) begin
                n_cmp++;
                if (w_valid !== 1'b1 || w_data !== pd || w_index !== pi || w_last !== pl) begin
                    n_err++;
                    $display("FAIL stall_hold: v=%b d=%h i=%0d l=%b required v=1 d=%h i=%0d l=%b",
                             w_valid, w_data, w_index, w_last, pd, pi, pl);
                end
            end
            w_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            stalled = 0;
            if (w_valid === 1'b1) begin
                if (w_ready) begin
                    n_cmp++;
                    if (w_data !== exp_out(n) || w_index !== 6'(n) || w_last !== logic'(n == 63)) begin
                        n_err++;
                        $display("FAIL word_%0d: d=%h i=%0d l=%b required d=%h i=%0d l=%b",
                                 n, w_data, w_index, w_last, exp_out(n), n, n == 63);
                    end
                    got[n] = w_data;
                    n++;
                end else begin
                    stalled = 1;
                    pd = w_data;
                    pi = w_index;
                    pl = w_last;
                end
            end
            tick();
            cyc++;
        end
        w_ready = 0;
        last_cycles = cyc;
        n_cmp++;
        if (n != words) begin
            n_err++;
            $display("FAIL consume_timeout: got %0d words required %0d", n, words);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (block_ready !== 1'b1 || w_valid !== 1'b0 || w_last !== 1'b0) begin
            n_err++;
            $display("FAIL %s: ready=%b valid=%b last=%b required ready=1 valid=0 last=0",
                     name, block_ready, w_valid, w_last);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        reset = 0;
        check_idle("reset_ctrl");
        n_cmp++;
        if (w_data !== 32'h0 || w_index !== 6'd0) begin
            n_err++;
            $display("FAIL reset_data: d=%h i=%0d required d=0 i=0", w_data, w_index);
        end
    endtask

    task automatic test_abc();
        model(abc_blk);
        offer(abc_blk);
        consume(64, 0);
        n_cmp++;
        if (last_cycles != 64) begin
            n_err++;
            $display("FAIL abc_throughput: %0d cycles required 64", last_cycles);
        end
        check_idle("abc_done");
`ifdef SCHED_ADD_K_EN
        n_cmp++;
        if (got[0] !== 32'hA3EC9318) begin
            n_err++;
            $display("FAIL abc_k0: got %h required a3ec9318", got[0]);
        end
`else
        n_cmp++;
        if (got[16] !== 32'h61626380 || got[17] !== 32'h000F0000 ||
            got[18] !== 32'h7DA86405 || got[63] !== 32'h12B1EDEB) begin
            n_err++;
            $display("FAIL abc_spot: W16=%h W17=%h W18=%h W63=%h required 61626380 000f0000 7da86405 12b1edeb",
                     got[16], got[17], got[18], got[63]);
        end
`endif
    endtask

    task automatic test_padder_block();
        model(pad_blk);
        offer(pad_blk);
        consume(64, 0);
        check_idle("pad_done");
`ifndef SCHED_ADD_K_EN
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin
                n_err++;
                $display("FAIL pad_w%0d: got %h required 00000000", i, got[i]);
            end
        end
        n_cmp++;
        if (got[8] !== 32'h80000000 || got[15] !== 32'h00000100 || got[17] !== 32'h00A00000) begin
            n_err++;
            $display("FAIL pad_spot: W8=%h W15=%h W17=%h required 80000000 00000100 00a00000",
                     got[8], got[15], got[17]);
        end
`endif
    endtask

    task automatic test_stall();
        model(abc_blk);
        offer(abc_blk);
        consume(64, 50);
        check_idle("stall_done");
    endtask

    task automatic test_reset_mid();
        model(abc_blk);
        offer(abc_blk);
        consume(20, 0);
        n_cmp++;
        if (w_valid !== 1'b1 || w_index !== 6'd20) begin
            n_err++;
            $display("FAIL mid_pos: valid=%b i=%0d required valid=1 i=20", w_valid, w_index);
        end
        reset = 1;
        w_ready = 1;
        tick();
        reset = 0;
        w_ready = 0;
        check_idle("mid_reset");
        n_cmp++;
        if (w_data !== 32'h0 || w_index !== 6'd0) begin
            n_err++;
            $display("FAIL mid_reset_data: d=%h i=%0d required d=0 i=0", w_data, w_index);
        end
        model(pad_blk);
        offer(pad_blk);
        consume(64, 0);
    endtask

    task automatic test_back_to_back();
        model(abc_blk);
        block_data = abc_blk;
        block_valid = 1;
        tick();
        block_data = pad_blk;
        consume(64, 0);
        n_cmp++;
        if (last_cycles != 64) begin
            n_err++;
            $display("FAIL b2b_throughput: %0d cycles required 64", last_cycles);
        end
        check_idle("b2b_gap");
        model(pad_blk);
        tick();
        block_valid = 0;
        consume(64, 0);
        check_idle("b2b_done");
    endtask

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;
        pad_blk = '0;
        pad_blk[511-32*8 -: 32] = 32'h80000000;
        pad_blk[31:0] = 32'h00000100;
        @(negedge clk);
        test_reset();
        test_abc();
        test_padder_block();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
